count_register_loader: RTL and testbench

- Upstream stage of the 8254 counter. Accepts control-word and data-bus byte writes and assembles the 16-bit initial count.
- Presents the assembled count as new_count with a one-cycle load strobe to the counting element.
- Also provides the read-back path: counter-latch command and LSB/MSB read sequencing of the counter's current value.

---
 rtl/count_register_loader_if.sv | 28 ++
 rtl/count_register_loader.sv | 88 ++++++++
 tb/tb_count_register_loader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/count_register_loader_if.sv
// count_register_loader_if: control/data bus and count hand-off between the 8254 host side and the count loader
interface count_register_loader_if #(
    parameter int BYTE_W  = 8,
    parameter int COUNT_W = 16
);
    logic               ctrl_wr;
    logic [7:0]         ctrl_word;
    logic               data_wr;
    logic [BYTE_W-1:0]  data_in;
    logic               rd;
    logic [COUNT_W-1:0] current_count;
    logic [COUNT_W-1:0] new_count;
    logic               load;
    logic [2:0]         mode;
    logic               bcd;
    logic               null_count;
    logic [BYTE_W-1:0]  data_out;

    modport master (
        output ctrl_wr, ctrl_word, data_wr, data_in, rd, current_count,
        input  new_count, load, mode, bcd, null_count, data_out
    );

    modport slave (
        input  ctrl_wr, ctrl_word, data_wr, data_in, rd, current_count,
        output new_count, load, mode, bcd, null_count, data_out
    );
endinterface

// File: rtl/count_register_loader.sv
// count_register_loader: assembles 8254 initial counts from byte writes and sequences latched/live count read-back
module count_register_loader #(
    parameter int BYTE_W  = 8,
    parameter int COUNT_W = 16
) (
    input logic clk,
    input logic rst,
    count_register_loader_if.slave bus
);
    logic [1:0]         rw;
    logic               wr_msb;
    logic               rd_msb;
    logic               latch_full;
    logic [BYTE_W-1:0]  lsb_buf;
    logic [COUNT_W-1:0] latch_val;
    logic [COUNT_W-1:0] wr_count;
    logic [COUNT_W-1:0] rd_src;
    logic [BYTE_W-1:0]  rd_byte;
    logic               wr_done;
    logic               rd_done;
    logic               unused_sc;

    assign unused_sc = ^bus.ctrl_word[7:6];

    // Decode the byte that completes a count and the byte a read returns
    always_comb begin
        wr_done  = (rw == 2'b11) ? wr_msb : 1'b1;
        wr_count = (rw == 2'b01) ? {{BYTE_W{1'b0}}, bus.data_in} :
                   (rw == 2'b10) ? {bus.data_in, {BYTE_W{1'b0}}} : {bus.data_in, lsb_buf};
        rd_src   = latch_full ? latch_val : bus.current_count;
        rd_byte  = (rw == 2'b10 || (rw == 2'b11 && rd_msb)) ? rd_src[COUNT_W-1:BYTE_W] : rd_src[BYTE_W-1:0];
        rd_done  = (rw == 2'b11) ? rd_msb : 1'b1;
    end

    // Control words take priority; otherwise data writes and reads proceed on independent pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            rw             <= 2'b00;
            wr_msb         <= 1'b0;
            rd_msb         <= 1'b0;
            latch_full     <= 1'b0;
            lsb_buf        <= '0;
            latch_val      <= '0;
            bus.new_count  <= '0;
            bus.load       <= 1'b0;
            bus.mode       <= 3'd0;
            bus.bcd        <= 1'b0;
            bus.null_count <= 1'b0;
            bus.data_out   <= '0;
        end else begin
            bus.load <= 1'b0;
            if (bus.ctrl_wr) begin
                if (bus.ctrl_word[5:4] != 2'b00) begin
                    rw             <= bus.ctrl_word[5:4];
                    bus.mode       <= bus.ctrl_word[3:1];
                    bus.bcd        <= bus.ctrl_word[0];
                    wr_msb         <= 1'b0;
                    rd_msb         <= 1'b0;
                    latch_full     <= 1'b0;
                    bus.null_count <= 1'b1;
                end else if (!latch_full) begin
                    latch_val  <= bus.current_count;
                    latch_full <= 1'b1;
                end
            end else begin
                if (bus.data_wr && rw != 2'b00) begin
                    if (wr_done) begin
                        bus.new_count  <= wr_count;
                        bus.load       <= 1'b1;
                        bus.null_count <= 1'b0;
                        wr_msb         <= 1'b0;
                    end else begin
                        lsb_buf <= bus.data_in;
                        wr_msb  <= 1'b1;
                    end
                end
                if (bus.rd) begin
                    bus.data_out <= (rw == 2'b00) ? '0 : rd_byte;
                    if (rw != 2'b00) begin
                        rd_msb <= (rw == 2'b11) && !rd_msb;
                        if (rd_done)
                            latch_full <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_count_register_loader.sv
// tb_count_register_loader: directed test-plan steps plus random traffic checked against a queue-based count model
module tb_count_register_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    count_register_loader_if #(.BYTE_W(8), .COUNT_W(16)) bus ();

    count_register_loader #(.BYTE_W(8), .COUNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [1:0]  m_rw;
    logic [2:0]  m_mode;
    logic        m_bcd;
    logic        m_null;
    logic        m_load;
    logic [15:0] m_new;
    logic [7:0]  m_out;
    logic [7:0]  m_lsb_q[$];
    logic [15:0] m_latch_q[$];
    int          m_reads_left;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model(input logic rs, input logic cw, input logic [7:0] cword, input logic dw,
                         input logic [7:0] din, input logic r, input logic [15:0] cur);
        logic [15:0] src;
        m_load = 1'b0;
        if (rs) begin
            m_rw = 0; m_mode = 0; m_bcd = 0; m_null = 0; m_new = 0; m_out = 0;
            m_lsb_q.delete(); m_latch_q.delete(); m_reads_left = 0;
        end else if (cw) begin
            if (cword[5:4] != 2'b00) begin
                m_rw = cword[5:4]; m_mode = cword[3:1]; m_bcd = cword[0]; m_null = 1'b1;
                m_lsb_q.delete(); m_latch_q.delete();
                m_reads_left = (m_rw == 2'b11) ? 2 : 1;
            end else if (m_latch_q.size() == 0) begin
                m_latch_q.push_back(cur);
            end
        end else begin
            if (dw && m_rw != 2'b00) begin
                if (m_rw == 2'b11 && m_lsb_q.size() == 0) begin
                    m_lsb_q.push_back(din);
                end else begin
                    m_new  = (m_rw == 2'b01) ? 16'(din) : (m_rw == 2'b10) ? {din, 8'h00} : {din, m_lsb_q.pop_front()};
                    m_load = 1'b1;
                    m_null = 1'b0;
                end
            end
            if (r) begin
                if (m_rw == 2'b00) begin
                    m_out = 8'h00;
                end else begin
                    src = (m_latch_q.size() != 0) ? m_latch_q[0] : cur;
                    m_out = (m_rw == 2'b10 || (m_rw == 2'b11 && m_reads_left == 1)) ? src[15:8] : src[7:0];
                    m_reads_left--;
                    if (m_reads_left == 0) begin
                        m_latch_q.delete();
                        m_reads_left = (m_rw == 2'b11) ? 2 : 1;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic rs, input logic cw, input logic [7:0] cword, input logic dw,
                        input logic [7:0] din, input logic r, input logic [15:0] cur);
        rst = rs;
        bus.ctrl_wr = cw; bus.ctrl_word = cword; bus.data_wr = dw; bus.data_in = din;
        bus.rd = r; bus.current_count = cur;
        @(posedge clk);
        model(rs, cw, cword, dw, din, r, cur);
        #1;
        chk("new_count", bus.new_count, m_new);
        chk("load", 16'(bus.load), 16'(m_load));
        chk("mode", 16'(bus.mode), 16'(m_mode));
        chk("bcd", 16'(bus.bcd), 16'(m_bcd));
        chk("null_count", 16'(bus.null_count), 16'(m_null));
        chk("data_out", 16'(bus.data_out), 16'(m_out));
    endtask

    task automatic ctl(input logic [7:0] w, input logic [15:0] cur);
        step(1'b0, 1'b1, w, 1'b0, 8'h00, 1'b0, cur);
    endtask

    task automatic wrb(input logic [7:0] b);
        step(1'b0, 1'b0, 8'h00, 1'b1, b, 1'b0, 16'h0000);
    endtask

    task automatic rdb(input logic [15:0] cur);
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, cur);
    endtask

    initial begin
        step(1'b1, 0, 8'h00, 0, 8'h00, 0, 16'h0000);
        chk("rst_new", bus.new_count, 16'h0000);
        ctl(8'h30, 16'h0);
        chk("tp1_null_set", 16'(bus.null_count), 16'h1);
        wrb(8'h34);
        chk("tp1_no_load_lsb", 16'(bus.load), 16'h0);
        wrb(8'h12);
        chk("tp1_new", bus.new_count, 16'h1234);
        chk("tp1_load", 16'(bus.load), 16'h1);
        chk("tp1_null_clr", 16'(bus.null_count), 16'h0);
        step(1'b0, 0, 8'h00, 0, 8'h00, 0, 16'h0);
        chk("tp1_load_one_cycle", 16'(bus.load), 16'h0);
        ctl(8'h14, 16'h0);
        wrb(8'h03);
        chk("tp2_new", bus.new_count, 16'h0003);
        chk("tp2_mode", 16'(bus.mode), 16'h2);
        ctl(8'h24, 16'h0);
        wrb(8'h04);
        chk("tp2_msb_only", bus.new_count, 16'h0400);
        ctl(8'h30, 16'h0);
        wrb(8'h55);
        ctl(8'h30, 16'h0);
        wrb(8'h66);
        chk("tp3_no_load", 16'(bus.load), 16'h0);
        wrb(8'h77);
        chk("tp3_new", bus.new_count, 16'h7766);
        ctl(8'h00, 16'hABCD);
        rdb(16'h1111);
        chk("tp4_lsb", 16'(bus.data_out), 16'h00CD);
        rdb(16'h1111);
        chk("tp4_msb", 16'(bus.data_out), 16'h00AB);
        rdb(16'h1111);
        chk("tp4_live", 16'(bus.data_out), 16'h0011);
        rdb(16'h1111);
        ctl(8'h00, 16'h2222);
        ctl(8'h00, 16'h3333);
        rdb(16'h4444);
        rdb(16'h4444);
        chk("tp5_first_latch_kept", 16'(bus.data_out), 16'h0022);
        step(1'b0, 1'b1, 8'h30, 1'b1, 8'h99, 1'b1, 16'h0);
        wrb(8'h01);
        chk("tp5_ptr_lsb", 16'(bus.load), 16'h0);
        wrb(8'h02);
        chk("tp5_new", bus.new_count, 16'h0201);
        step(1'b1, 0, 8'h00, 0, 8'h00, 0, 16'h0);
        wrb(8'hFF);
        chk("tp6_unprog_load", 16'(bus.load), 16'h0);
        chk("tp6_unprog_new", bus.new_count, 16'h0000);
        ctl(8'h30, 16'h0);
        wrb(8'h34);
        step(1'b1, 0, 8'h00, 0, 8'h00, 0, 16'h0);
        wrb(8'h12);
        chk("tp6_after_rst_load", 16'(bus.load), 16'h0);
        chk("tp6_after_rst_new", bus.new_count, 16'h0000);
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 64) == 0, ($urandom % 6) == 0, 8'($urandom), $urandom % 2 == 0,
                 8'($urandom), ($urandom % 3) == 0, 16'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
